// File: rtl/reg_store_serializer_pkg.sv
// Shared definitions for the register store serializer: the state encoding,
// the byte width and a byte-lane selector.
package reg_store_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_LO = 2'b01,
        WR_HI = 2'b10,
        FIN   = 2'b11
    } state_t;

    localparam int BYTE_W = 8;

    // Little-endian lane select: hi=0 gives the low byte, hi=1 the high byte.
    function automatic logic [BYTE_W-1:0] byte_of(input logic [2*BYTE_W-1:0] value,
                                                  input logic                hi);
        logic [BYTE_W-1:0] lane;
        if (hi) begin
            lane = value[2*BYTE_W-1:BYTE_W];
        end else begin
            lane = value[BYTE_W-1:0];
        end
        return lane;
    endfunction

endpackage

// File: rtl/reg_store_serializer.sv
// Stores a 16-bit register value to a byte-wide memory as one or two
// little-endian byte writes with a held request / acknowledge handshake.
module reg_store_serializer
    import reg_store_serializer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Word,
    input  logic [15:0]         Data,
    input  logic [ADDR_W-1:0]   Address,
    output logic                MemReq,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [BYTE_W-1:0]   MemData,
    input  logic                MemAck,
    output logic                Busy,
    output logic                Done
);

    state_t              state_r;
    state_t              state_nxt_s;

    logic [15:0]         data_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                word_r;
    logic [15:0]         data_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic                word_nxt_s;

    logic                mem_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [BYTE_W-1:0]   mem_data_r;
    logic                busy_r;
    logic                done_r;
    logic                mem_req_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_nxt_s;
    logic [BYTE_W-1:0]   mem_data_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; acknowledges outside the write states have no effect.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_nxt_s = WR_LO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_LO: begin
                if (MemAck) begin
                    state_nxt_s = word_r ? WR_HI : FIN;
                end else begin
                    state_nxt_s = WR_LO;
                end
            end
            WR_HI: begin
                if (MemAck) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = WR_HI;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request capture: only an idle Start loads new values.
    always_comb begin
        data_nxt_s = data_r;
        addr_nxt_s = addr_r;
        word_nxt_s = word_r;
        if (state_r == IDLE && Start) begin
            data_nxt_s = Data;
            addr_nxt_s = Address;
            word_nxt_s = Word;
        end else begin
            data_nxt_s = data_r;
            addr_nxt_s = addr_r;
            word_nxt_s = word_r;
        end
    end

    // Captured request registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_r <= 16'h0000;
            addr_r <= '0;
            word_r <= 1'b0;
        end else begin
            data_r <= data_nxt_s;
            addr_r <= addr_nxt_s;
            word_r <= word_nxt_s;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        mem_req_nxt_s  = 1'b0;
        mem_addr_nxt_s = mem_addr_r;
        mem_data_nxt_s = mem_data_r;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_nxt_s)
            WR_LO: begin
                mem_req_nxt_s  = 1'b1;
                mem_addr_nxt_s = addr_nxt_s;
                mem_data_nxt_s = byte_of(data_nxt_s, 1'b0);
                busy_nxt_s     = 1'b1;
            end
            WR_HI: begin
                mem_req_nxt_s  = 1'b1;
                mem_addr_nxt_s = addr_r + ADDR_W'(1);
                mem_data_nxt_s = byte_of(data_r, 1'b1);
                busy_nxt_s     = 1'b1;
            end
            FIN: begin
                done_nxt_s = 1'b1;
            end
            IDLE: begin
                mem_req_nxt_s = 1'b0;
            end
            default: begin
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            mem_data_r <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            mem_req_r  <= mem_req_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            mem_data_r <= mem_data_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign MemReq  = mem_req_r;
    assign MemAddr = mem_addr_r;
    assign MemData = mem_data_r;
    assign Busy    = busy_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_reg_store_serializer.sv
// Self-checking bench for reg_store_serializer: expected byte writes are
// queued per scenario and compared against writes seen on the memory port.
module tb_reg_store_serializer;

    localparam int AW = 16;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic          Word;
    logic [15:0]   Data;
    logic [AW-1:0] Address;
    logic          MemReq;
    logic [AW-1:0] MemAddr;
    logic [7:0]    MemData;
    logic          MemAck;
    logic          Busy;
    logic          Done;

    int checks;
    int failures;
    int done_cnt;

    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] obs_q[$];

    reg_store_serializer #(.ADDR_W(AW)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Word    (Word),
        .Data    (Data),
        .Address (Address),
        .MemReq  (MemReq),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .MemAck  (MemAck),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // A byte is written at the rising edge following a cycle with MemReq and MemAck high.
    always @(negedge Clock) begin
        if (!Reset && MemReq && MemAck) obs_q.push_back({MemAddr, MemData});
        if (Done) done_cnt++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Word = 1'b1; Data = 16'hFFFF;
        Address = 16'hFFFF; MemAck = 1'b1;
        tick(); tick();
        Reset = 1'b0; Start = 1'b0; MemAck = 1'b0;
        checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b exp=0", MemReq); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL reset_memaddr got=%h exp=0000", MemAddr); end
        checks++; if (MemData !== 8'h00) begin failures++; $display("FAIL reset_memdata got=%h exp=00", MemData); end
        tick();
        checks++; if (MemReq !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL reset_idle req=%b busy=%b exp=0/0", MemReq, Busy); end
        obs_q.delete(); exp_q.delete(); done_cnt = 0;
    endtask

    // Start a store with MemAck held high, return the cycle (Start cycle = 1) in which Done appears.
    task automatic store_ack_always(input logic w, input logic [15:0] d, input logic [AW-1:0] a,
                                    output int done_cyc, output logic busy_seen_ok);
        int cyc;
        done_cyc = 0; busy_seen_ok = 1'b1;
        MemAck = 1'b1; Start = 1'b1; Word = w; Data = d; Address = a;
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            Start = 1'b0;
            cyc++;
            if (Done) begin done_cyc = cyc; break; end
            if (Busy !== 1'b1) busy_seen_ok = 1'b0;
        end
    endtask

    task automatic test_word_store();
        int dc; logic bok; int n;
        exp_q.push_back({16'h0100, 8'h5A});
        exp_q.push_back({16'h0101, 8'hA5});
        store_ack_always(1'b1, 16'hA55A, 16'h0100, dc, bok);
        checks++; if (dc != 4) begin failures++; $display("FAIL word_done_cycle got=%0d exp=4", dc); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL word_busy got=0 exp=1 in write states"); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL word_busy_fin got=%b exp=0", Busy); end
        tick();
        MemAck = 1'b0;
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL word_done_width got=%b exp=0", Done); end
        n = exp_q.size();
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL word_count got=%0d exp=%0d", obs_q.size(), n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [AW+7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL word_write got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_byte_store();
        int dc; logic bok; int n;
        exp_q.push_back({16'h0200, 8'h34});
        store_ack_always(1'b0, 16'h1234, 16'h0200, dc, bok);
        checks++; if (dc != 3) begin failures++; $display("FAIL byte_done_cycle got=%0d exp=3", dc); end
        tick();
        MemAck = 1'b0;
        tick();
        n = exp_q.size();
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL byte_count got=%0d exp=%0d", obs_q.size(), n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [AW+7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL byte_write got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_addr_wrap();
        int dc; logic bok; int n;
        exp_q.push_back({16'hFFFF, 8'hEF});
        exp_q.push_back({16'h0000, 8'hBE});
        store_ack_always(1'b1, 16'hBEEF, 16'hFFFF, dc, bok);
        checks++; if (dc != 4) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=4", dc); end
        tick();
        MemAck = 1'b0;
        n = exp_q.size();
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size(), n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [AW+7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wrap_write got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ack_wait();
        logic got_done; int n;
        exp_q.push_back({16'h1230, 8'h3E});
        exp_q.push_back({16'h1231, 8'h9C});
        MemAck = 1'b0; Start = 1'b1; Word = 1'b1; Data = 16'h9C3E; Address = 16'h1230;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL wait_req[%0d] got=%b exp=1", i, MemReq); end
            checks++; if (MemAddr !== 16'h1230) begin failures++; $display("FAIL wait_addr[%0d] got=%h exp=1230", i, MemAddr); end
            checks++; if (MemData !== 8'h3E) begin failures++; $display("FAIL wait_data[%0d] got=%h exp=3E", i, MemData); end
            if (i == 1) begin
                Start = 1'b1; Word = 1'b0; Data = 16'h0000; Address = 16'h0000;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Start = 1'b0; MemAck = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) begin got_done = 1'b1; break; end
            tick();
        end
        checks++; if (got_done !== 1'b1) begin failures++; $display("FAIL wait_done got=0 exp=1 within 20 cycles"); end
        MemAck = 1'b0;
        tick();
        n = exp_q.size();
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL wait_count got=%0d exp=%0d", obs_q.size(), n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [AW+7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wait_write got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int dc0; int n;
        exp_q.push_back({16'h4000, 8'h88});
        dc0 = done_cnt;
        MemAck = 1'b1; Start = 1'b1; Word = 1'b1; Data = 16'h7788; Address = 16'h4000;
        tick();
        Start = 1'b0;
        tick();
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h4001) begin failures++; $display("FAIL mid_in_hi req=%b addr=%h exp=1/4001", MemReq, MemAddr); end
        Reset = 1'b1; MemAck = 1'b0;
        tick();
        Reset = 1'b0;
        checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL mid_req got=%b exp=0", MemReq); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", Busy); end
        checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL mid_addr got=%h exp=0000", MemAddr); end
        MemAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (MemReq !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
                failures++; $display("FAIL mid_ack_ignored[%0d] req=%b busy=%b done=%b exp=0/0/0", i, MemReq, Busy, Done);
            end
        end
        MemAck = 1'b0;
        checks++; if (done_cnt != dc0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt - dc0, 0); end
        n = exp_q.size();
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", obs_q.size(), n); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [AW+7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL mid_write got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        Reset = 1'b1; Start = 1'b0; Word = 1'b0; Data = 16'h0000;
        Address = '0; MemAck = 1'b0;
        test_reset();
        test_word_store();
        test_byte_store();
        test_addr_wrap();
        test_ack_wait();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_store_serializer.md
REG_STORE_SERIALIZER -- requirements
Module: reg_store_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have port Clock  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port Start  in  1  one-cycle request to store a register value.
REQ-005 SHALL have port Word  in  1  1 = store 16-bit value as two bytes; 0 = store low byte only.
REQ-006 SHALL have port Data  in  16  register value to store, sampled when a Start is accepted.
REQ-007 SHALL have port Address  in  ADDR_W  byte address of the low byte, sampled when a Start is accepted.
REQ-008 SHALL have port MemReq  out  1  memory write request, held until acknowledged.
REQ-009 SHALL have port MemAddr  out  ADDR_W  byte address of the current write.
REQ-010 SHALL have port MemData  out  8  byte being written.
REQ-011 SHALL have port MemAck  in  1  memory accepted the current byte.
REQ-012 SHALL have port Busy  out  1  high from the cycle after an accepted Start until Done.
REQ-013 SHALL have port Done  out  1  one-cycle pulse when the last byte is acknowledged.

Function
REQ-014 SHALL implement states IDLE, WR_LO, WR_HI, FIN.
REQ-015 IDLE: Start=1 SHALL capture Data, Address and Word, then go to WR_LO on the next edge; Start=0 SHALL leave the state unchanged.
REQ-016 WR_LO SHALL drive MemReq=1, MemAddr=captured Address and MemData=Data[7:0].
REQ-017 WR_LO with MemAck=1 SHALL go to WR_HI if Word=1, else to FIN.
REQ-018 WR_HI SHALL drive MemReq=1, MemAddr=Address+1 (mod 2^ADDR_W) and MemData=Data[15:8]; MemAck=1 SHALL go to FIN.
REQ-019 Byte order SHALL be little-endian: low byte at the lower address, matching the register low/high byte-write functions.
REQ-020 FIN SHALL assert Done=1 and MemReq=0 for exactly one cycle, then return to IDLE.
REQ-021 MemReq, MemAddr and MemData SHALL stay stable while MemReq=1 and MemAck=0; there SHALL be no limit on wait cycles.
REQ-022 MemAck while in IDLE or FIN SHALL be ignored.
REQ-023 Start while Busy=1 SHALL be ignored and SHALL NOT alter the captured values.
REQ-024 Start in the FIN cycle SHALL be ignored; the earliest new accept SHALL be the cycle after Done.
REQ-025 An ack-every-cycle word store SHALL take 4 cycles from Start to Done: the accept edge, WR_LO, WR_HI, FIN. A byte store SHALL take 3.
REQ-026 Address=all-ones with Word=1 SHALL wrap the high-byte address to 0.
REQ-027 Busy SHALL be 1 in WR_LO and WR_HI, and 0 in IDLE and FIN.
REQ-028 In IDLE, MemAddr and MemData SHALL hold their last driven values; the observable contract SHALL rely only on MemReq.

Reset
REQ-029 Reset=1 at a clock edge SHALL force IDLE, MemReq=0, Busy=0, Done=0, MemAddr=0, MemData=0 and clear the captured registers, overriding every other input.
REQ-030 Reset mid-transfer SHALL abandon the remaining byte with no further MemReq; a MemAck arriving after reset SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'b00, WR_LO=2'b01, WR_HI=2'b10, FIN=2'b11) and the byte-width constant 8.
REQ-032 The block SHALL be a single module with no sub-modules; the address incrementer SHALL be inline.

Verification
REQ-033 SHALL test: Start, Word=1, Data=16'hA55A, Address=16'h0100, ack every cycle -> writes 8'h5A@0100 then 8'hA5@0101; Done in the 4th cycle after Start.
REQ-034 SHALL test: Word=0, Data=16'h1234, Address=16'h0200 -> single write 8'h34@0200; Done in the 3rd cycle; no write to 0201.
REQ-035 SHALL test: Address=16'hFFFF, Word=1, Data=16'hBEEF -> 8'hEF@FFFF then 8'hBE@0000.
REQ-036 SHALL test: MemAck held low 5 cycles in WR_LO -> MemReq, MemAddr and MemData stable for all 5 cycles; Start=1 with Data=16'h0000 during the wait -> captured value unchanged.
REQ-037 SHALL test: Reset asserted in WR_HI -> next cycle MemReq=0, Busy=0, no Done pulse; a subsequent MemAck causes no state change.
